// File: rtl/elastic_pipe_pkg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_pkg
// Shared definitions for the elastic pipeline register slice.
//
// Contents:
//   DWIDTH_DEFAULT  default bits per lane word (signed fixed-point)
//   LANES_DEFAULT   default number of parallel lanes per stage
//   DEPTH_MAX       largest supported number of stages
//   lane_t          one signed lane word at the default width
//   occ_width()     width of a counter that can hold 0..depth
// -----------------------------------------------------------------------------
package elastic_pipe_pkg;

   localparam int DWIDTH_DEFAULT = 32;
   localparam int LANES_DEFAULT  = 4;
   localparam int DEPTH_MAX      = 16;

   typedef logic signed [DWIDTH_DEFAULT-1:0] lane_t;

   // A count of valid stages ranges over 0..depth inclusive.
   function automatic int occ_width(input int depth);
      return $clog2(depth + 1);
   endfunction

endpackage

// File: rtl/elastic_pipe_reg_pipe_stage.sv
// -----------------------------------------------------------------------------
// pipe_stage
// One stage of the elastic pipeline: a valid bit plus a LANES*DWIDTH data word.
//
// Ports:
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-high; clears valid and data
//   clear   in   flush request; clears valid, overrides load
//   load    in   capture d_in and mark the stage valid
//   hold    in   stage is occupied and cannot move; keep valid and data
//   d_in    in   W-bit word from the upstream stage (or the block input)
//   v       out  stage valid
//   d       out  stage data word
//
// When neither load nor hold is set the stage is either empty or has just
// handed its word downstream, so valid falls and the data register keeps its
// old (now don't-care) contents.
// -----------------------------------------------------------------------------
module pipe_stage #(
   parameter int W = 128
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         clear,
   input  logic         load,
   input  logic         hold,
   input  logic [W-1:0] d_in,
   output logic         v,
   output logic [W-1:0] d
);

   always_ff @(posedge clk) begin
      if (reset) begin
         v <= 1'b0;
         d <= '0;
      end else begin
         if (clear) begin
            v <= 1'b0;
         end else if (load) begin
            v <= 1'b1;
         end else if (!hold) begin
            v <= 1'b0;
         end

         // Data only moves on a real load; a flushed load is discarded.
         if (load && !clear) begin
            d <= d_in;
         end
      end
   end

endmodule

// File: rtl/elastic_pipe_reg.sv
// -----------------------------------------------------------------------------
// elastic_pipe_reg
// Multi-lane elastic pipeline register with valid/ready backpressure and
// bubble collapse. DEPTH stages each carry LANES signed DWIDTH-bit words that
// always advance together; data is never modified and lanes never mix.
//
// Parameters:
//   DWIDTH  bits per lane word
//   LANES   lanes per stage
//   DEPTH   number of stages, 1..DEPTH_MAX
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous, active-high reset
//   flush      in   synchronous clear of all stage valids
//   in_valid   in   upstream word-set valid
//   in_ready   out  block accepts a word-set this cycle
//   in_data    in   lane k = in_data[k*DWIDTH +: DWIDTH]
//   out_valid  out  last stage holds valid data
//   out_ready  in   downstream accepts this cycle
//   out_data   out  last stage contents, same lane packing
//   occupancy  out  registered count of valid stages
//                   (only when ELASTIC_PIPE_OCC_EN is defined)
//
// Optional feature macro: ELASTIC_PIPE_OCC_EN adds the occupancy counter and
// port. Without it the block is otherwise identical.
//
// The ready chain is purely combinational from out_ready back to in_ready,
// so a full pipe with out_ready=1 shifts and accepts in the same cycle.
// -----------------------------------------------------------------------------
module elastic_pipe_reg
   import elastic_pipe_pkg::*;
#(
   parameter int DWIDTH = DWIDTH_DEFAULT,
   parameter int LANES  = LANES_DEFAULT,
   parameter int DEPTH  = 3
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      flush,
   input  logic                      in_valid,
   output logic                      in_ready,
   input  logic [LANES*DWIDTH-1:0]   in_data,
   output logic                      out_valid,
   input  logic                      out_ready,
   output logic [LANES*DWIDTH-1:0]   out_data
`ifdef ELASTIC_PIPE_OCC_EN
   ,
   output logic [occ_width(DEPTH)-1:0] occupancy
`endif
);

   localparam int W = LANES * DWIDTH;

   logic [DEPTH-1:0] v;      // stage valids
   logic [DEPTH-1:0] adv;    // stage hands its word downstream this cycle
   logic [DEPTH-1:0] free;   // stage can take a new word this cycle
   logic [DEPTH-1:0] load;   // stage captures a word this cycle
   logic [DEPTH-1:0] hold;   // stage is stalled with valid data
   logic [W-1:0]     d [DEPTH];
   logic             accept;

   // Walk from the tail toward the head so each stage sees the freshly
   // computed free of its successor. An empty stage is always free, which is
   // what lets a bubble collapse behind a stalled tail.
   always_comb begin
      adv  = '0;
      free = '0;
      for (int i = DEPTH - 1; i >= 0; i--) begin
         if (i == DEPTH - 1) begin
            adv[i] = v[i] & out_ready;
         end else begin
            adv[i] = v[i] & free[i+1];
         end
         free[i] = ~v[i] | adv[i];
      end
   end

   assign in_ready = free[0] & ~flush & ~reset;
   assign accept   = in_valid & in_ready;

   // Stage array: stage 0 takes the block input, stage i takes stage i-1.
   for (genvar i = 0; i < DEPTH; i++) begin : g_stage
      if (i == 0) begin : g_head
         assign load[i] = accept;
         pipe_stage #(
            .W (W)
         ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .load  (load[i]),
            .hold  (hold[i]),
            .d_in  (in_data),
            .v     (v[i]),
            .d     (d[i])
         );
      end else begin : g_body
         assign load[i] = adv[i-1];
         pipe_stage #(
            .W (W)
         ) u_stage (
            .clk   (clk),
            .reset (reset),
            .clear (flush),
            .load  (load[i]),
            .hold  (hold[i]),
            .d_in  (d[i-1]),
            .v     (v[i]),
            .d     (d[i])
         );
      end
      assign hold[i] = ~free[i];
   end

   assign out_valid = v[DEPTH-1];
   assign out_data  = d[DEPTH-1];

`ifdef ELASTIC_PIPE_OCC_EN
   localparam int OW = occ_width(DEPTH);

   logic emit;
   assign emit = adv[DEPTH-1];

   // Accept and emit in the same cycle cancel, so the count only ever steps
   // by one. Flush empties every stage, so the count returns to zero.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         occupancy <= '0;
      end else if (accept && !emit) begin
         occupancy <= occupancy + OW'(1);
      end else if (!accept && emit) begin
         occupancy <= occupancy - OW'(1);
      end
   end
`endif

endmodule
